// File: rtl/knockout_injector.sv
// Inline fetch-stream injector: after a trigger hit and a programmed number of
// accepted beats, replaces the next cfg_len beats with a latched knockout word.
module knockout_injector #(
  parameter int INST_W = 32,
  parameter int DLY_W  = 8,
  parameter int LEN_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              arm,
  input  logic              disarm,
  input  logic [1:0]        trig_sel,
  input  logic              trig1,
  input  logic              trig2,
  input  logic [DLY_W-1:0]  cfg_delay,
  input  logic [LEN_W-1:0]  cfg_len,
  input  logic [INST_W-1:0] cfg_inst,
  input  logic [INST_W-1:0] inst_in,
  input  logic              inst_in_valid,
  output logic              inst_in_ready,
  output logic [INST_W-1:0] inst_out,
  output logic              inst_out_valid,
  input  logic              inst_out_ready,
  output logic              busy,
  output logic              fired,
  output logic              done
);

  typedef enum logic [2:0] {IDLE, ARMED, DELAY, INJECT, DONE} state_e;

  state_e             state_q;
  logic [DLY_W-1:0]   cfg_dly_q, dly_cnt_q;
  logic [LEN_W-1:0]   cfg_len_q, len_cnt_q;
  logic [INST_W-1:0]  cfg_inst_q;
  logic [1:0]         sel_q;
  logic               fired_q, done_q;
  logic               beat, hit;

  assign beat = inst_in_valid & inst_out_ready;

  always_comb begin
    hit = 1'b0;
    unique case (sel_q)
      2'b00: hit = trig1;
      2'b01: hit = trig2;
      2'b10: hit = trig1 | trig2;
      2'b11: hit = trig1 & trig2;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      cfg_dly_q  <= '0;
      cfg_len_q  <= '0;
      cfg_inst_q <= '0;
      sel_q      <= '0;
      dly_cnt_q  <= '0;
      len_cnt_q  <= '0;
      fired_q    <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (disarm) begin
        // disarm pre-empts arm, hits and the final beat alike
        state_q <= IDLE;
        fired_q <= 1'b0;
      end else begin
        unique case (state_q)
          IDLE, DONE: if (arm) begin
            cfg_dly_q  <= cfg_delay;
            cfg_len_q  <= cfg_len;
            cfg_inst_q <= cfg_inst;
            sel_q      <= trig_sel;
            fired_q    <= 1'b0;
            state_q    <= ARMED;
          end
          ARMED: if (hit) begin
            if (cfg_len_q == '0) begin
              state_q <= DONE;
              done_q  <= 1'b1;
              fired_q <= 1'b1;
            end else if (cfg_dly_q == '0) begin
              state_q   <= INJECT;
              len_cnt_q <= cfg_len_q;
            end else begin
              state_q   <= DELAY;
              dly_cnt_q <= cfg_dly_q;
            end
          end
          DELAY: if (beat) begin
            if (dly_cnt_q == DLY_W'(1)) begin
              state_q   <= INJECT;
              len_cnt_q <= cfg_len_q;
            end else begin
              dly_cnt_q <= dly_cnt_q - DLY_W'(1);
            end
          end
          INJECT: if (beat) begin
            if (len_cnt_q == LEN_W'(1)) begin
              state_q <= DONE;
              done_q  <= 1'b1;
              fired_q <= 1'b1;
            end else begin
              len_cnt_q <= len_cnt_q - LEN_W'(1);
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign inst_out       = (state_q == INJECT) ? cfg_inst_q : inst_in;
  assign inst_out_valid = inst_in_valid;
  assign inst_in_ready  = inst_out_ready;
  assign busy           = (state_q == ARMED) | (state_q == DELAY) | (state_q == INJECT);
  assign fired          = fired_q;
  assign done           = done_q;

endmodule

// File: doc/knockout_injector.md
Name: knockout_injector

Overview:
- Response side of the instruction-match trigger: consumes the trig1/trig2 pulses from the trigger comparator and, after a programmed delay, replaces instructions in the fetch stream with a programmed knockout word.
- Sits inline on the fetch-to-decode valid/ready path, passing instructions through unchanged except during the injection window.
- One-shot per arm, with sticky status for the formal/sim harness.

Parameters:
- INST_W, 32, instruction word width
- DLY_W, 8, width of delay counter (accepted beats)
- LEN_W, 4, width of injection length counter (accepted beats)

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low (0 = reset)
- arm  in  1  pulse; captures cfg_* and arms, honoured in IDLE or DONE only
- disarm  in  1  pulse; forces IDLE from any state; wins over arm
- trig_sel  in  2  00 trig1, 01 trig2, 10 trig1|trig2, 11 trig1&trig2
- trig1  in  1  match pulse, slot 0
- trig2  in  1  match pulse, slot 1
- cfg_delay  in  DLY_W  accepted beats between trigger and first injected beat
- cfg_len  in  LEN_W  number of beats to replace; 0 = no replacement
- cfg_inst  in  INST_W  knockout instruction word
- inst_in  in  INST_W  upstream instruction
- inst_in_valid  in  1  upstream valid
- inst_in_ready  out  1  equals inst_out_ready (combinational)
- inst_out  out  INST_W  inst_in, or latched cfg_inst in INJECT
- inst_out_valid  out  1  equals inst_in_valid (combinational)
- inst_out_ready  in  1  downstream ready
- busy  out  1  state is ARMED, DELAY or INJECT
- fired  out  1  sticky; set on entering DONE, cleared by arm/disarm/reset
- done  out  1  one-cycle pulse on entering DONE

Behaviour:
- Beat = inst_in_valid & inst_out_ready. The block never stalls or creates beats; valid/ready are pure feed-through.
- Reset (rst=0, async): state IDLE, counters 0, latched cfg 0, busy=0, fired=0, done=0. inst_out = inst_in immediately.
- IDLE: on arm (and no disarm), latch cfg_delay, cfg_len, cfg_inst and trig_sel, then go to ARMED. Trigger pulses are ignored.
- ARMED: a hit is evaluated each cycle from trig1/trig2 per the latched trig_sel. On a hit:
  - latched len==0 -> DONE
  - else delay==0 -> INJECT, len counter loaded
  - else -> DELAY, delay counter loaded
  - Transitions take effect next cycle. The hit cycle's beat is not counted and not replaced.
- DELAY: each beat decrements the delay counter. A beat while the counter==1 -> INJECT next cycle. No beat means no change. Further trigger pulses are ignored.
- INJECT: inst_out = latched cfg_inst (combinational on state). Each beat decrements the len counter. A beat while the counter==1 -> DONE. Upstream word is discarded on replaced beats.
- DONE: done=1 for the entry cycle only, fired=1 held. arm re-captures cfg and goes to ARMED, clearing fired.
- disarm in any state: IDLE next cycle, fired cleared, no done pulse. Same cycle as arm -> disarm wins. Same cycle as a hit or last beat -> IDLE, no DONE.
- arm in ARMED/DELAY/INJECT is ignored (cfg changes mid-run have no effect).
- Latency: with cfg_delay=D>0, the first replaced beat is the D+1-th beat after the hit cycle. With D=0, the first replaced beat is the first beat after the hit cycle.
- Counters never wrap: the load value is at least 1 and every decrement is guarded by a state exit at 1.

Test Plan:
- Reset and pass-through:
  - Stimulus: rst=0 mid-INJECT.
  - Response: same cycle busy=0, fired=0, inst_out = inst_in. inst_in=0x00A00093 streams unchanged while idle.
- Basic injection:
  - Stimulus: arm with delay=2, len=3, cfg_inst=0x00000013, trig_sel=00; trig1 pulse; continuous beats.
  - Response: beats 1-2 pass through, beats 3-5 show 0x00000013, done pulses once on the cycle after beat 5, then fired=1.
- Backpressure:
  - Stimulus: same config; inst_out_ready=0 for 4 cycles during DELAY and 3 cycles during INJECT.
  - Response: counts advance only on beats, exactly 3 words are replaced, inst_in_ready mirrors ready.
- Trigger select:
  - Stimulus: trig_sel=11; trig1 alone, then trig2 alone, then both in one cycle.
  - Response: only the coincident cycle starts the sequence. trig_sel=01 ignores trig1 pulses.
- Edge configs:
  - Stimulus: len=0 with a hit -> DONE next cycle, zero words replaced.
  - Stimulus: delay=0, len=1 -> only the first beat after the hit is replaced.
  - Stimulus: delay=255 -> the 256th beat is replaced.
- Arm/disarm races:
  - Stimulus: arm and disarm asserted together in IDLE -> stays IDLE.
  - Stimulus: disarm on the cycle of the last INJECT beat -> IDLE, no done pulse, fired=0.
  - Stimulus: arm in DELAY -> ignored, sequence completes with the original cfg.
